// File: rtl/serial_bus_arbiter_tx_pkg.sv
`default_nettype none
// ============================================================================
// Package     : bus_pkg
// Description : Shared frame definitions for the single-wire serial bus
//               (frame states, line levels, default CRC polynomial, sizing).
// Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    SRC   = 3'd2,
    DST   = 3'd3,
    DATA  = 3'd4,
    CRC   = 3'd5,
    STOP  = 3'd6
  } frame_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // x^4 + x + 1, top bit implicit
  localparam logic [3:0] DEFAULT_CRC_POLY = 4'b0011;

  // Bus cycles occupied by one frame, START through STOP inclusive
  function automatic int frame_len(input int addr_w, input int data_w, input int crc_w);
    return 2 + 2 * addr_w + data_w + crc_w;
  endfunction

  // Width of a down-counter able to hold max_w-1 (at least one bit)
  function automatic int cnt_width(input int max_w);
    return (max_w > 1) ? $clog2(max_w) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_bus_arbiter_tx_if.sv
`default_nettype none
// ============================================================================
// Interface   : serial_bus_arbiter_tx_if
// Description : Sender-channel request/payload bundle plus serial bus status.
//               master = sender register banks, slave = transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_bus_arbiter_tx_if #(
  parameter int N      = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 64
);
  logic [N-1:0]        req;
  logic [N*DATA_W-1:0] data;
  logic [N*ADDR_W-1:0] rx_addr;
  logic [N-1:0]        grant;
  logic                busy;
  logic                frame_done;
  logic                bus_out;

  modport master (
    output req, data, rx_addr,
    input  grant, busy, frame_done, bus_out
  );

  modport slave (
    input  req, data, rx_addr,
    output grant, busy, frame_done, bus_out
  );
endinterface
`default_nettype wire

// File: rtl/serial_bus_arbiter_tx_crc_serial.sv
`default_nettype none
// ============================================================================
// Module      : crc_serial
// Description : Bit-serial CRC register, MSB-first, zero initial value, no
//               final XOR. Shared between bus transmitter and receiver.
// Revision    : 1.0 - initial release
// ============================================================================
module crc_serial
  import bus_pkg::*;
#(
  parameter int                CRC_W    = 4,
  parameter logic [CRC_W-1:0]  CRC_POLY = CRC_W'(DEFAULT_CRC_POLY)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc
);

  logic w_fb;

  assign w_fb = crc[CRC_W-1] ^ bit_in;

  // Shift one message bit into the CRC; clr restarts it for a new frame
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      crc <= '0;
    end else if (clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= (crc << 1) ^ (w_fb ? CRC_POLY : '0);
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_bus_arbiter_tx.sv
`default_nettype none
// ============================================================================
// Module      : serial_bus_arbiter_tx
// Description : Round-robin arbiter over N sender channels that latches the
//               winner's payload and serialises START/SRC/DST/DATA/CRC/STOP
//               onto a single idle-high bus line.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_bus_arbiter_tx
  import bus_pkg::*;
#(
  parameter int               N        = 16,
  parameter int               ADDR_W   = 4,
  parameter int               DATA_W   = 64,
  parameter int               CRC_W    = 4,
  parameter logic [CRC_W-1:0] CRC_POLY = CRC_W'(DEFAULT_CRC_POLY)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  serial_bus_arbiter_tx_if.slave bus
);

  localparam int MAX_W = (ADDR_W > DATA_W) ? ((ADDR_W > CRC_W) ? ADDR_W : CRC_W)
                                           : ((DATA_W > CRC_W) ? DATA_W : CRC_W);
  localparam int CNT_W = cnt_width(MAX_W);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_START = START;
  localparam logic [2:0] S_SRC   = SRC;
  localparam logic [2:0] S_DST   = DST;
  localparam logic [2:0] S_DATA  = DATA;
  localparam logic [2:0] S_CRC   = CRC;
  localparam logic [2:0] S_STOP  = STOP;

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(CRC_W - 1);

  logic [2:0]        r_state, w_next_state;
  logic [CNT_W-1:0]  r_cnt, w_next_cnt, w_cnt_m1;
  logic              w_next_bit;
  logic [ADDR_W-1:0] r_rr_ptr, r_src, r_dst;
  logic [DATA_W-1:0] r_data;
  logic [N-1:0]      r_grant;
  logic              r_bus_out, r_busy, r_frame_done;

  logic [2*N-1:0]    w_req_dbl;
  logic [N-1:0]      w_rot;
  logic              w_any_req, w_take, w_crc_en;
  logic [ADDR_W-1:0] w_winner, w_win_addr;
  logic [DATA_W-1:0] w_win_data;
  logic [CRC_W-1:0]  w_crc;
  logic              w_src_bit, w_dst_bit, w_data_bit, w_crc_bit;

  // Requests rotated so that bit 0 is the channel at the round-robin pointer
  assign w_req_dbl = {bus.req, bus.req};
  assign w_rot     = N'(w_req_dbl >> r_rr_ptr);

  // Lowest rotated position wins; map it back to an absolute channel index
  always_comb begin
    w_any_req = 1'b0;
    w_winner  = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_any_req = 1'b1;
        w_winner  = (int'(r_rr_ptr) + j >= N) ? ADDR_W'(int'(r_rr_ptr) + j - N)
                                              : ADDR_W'(int'(r_rr_ptr) + j);
      end
    end
  end

  assign w_take     = (r_state == S_IDLE) && w_any_req;
  assign w_win_data = DATA_W'(bus.data >> (int'(w_winner) * DATA_W));
  assign w_win_addr = ADDR_W'(bus.rx_addr >> (int'(w_winner) * ADDR_W));

  // Field bits below the MSB, selected by the down-counter
  assign w_cnt_m1   = r_cnt - CNT_W'(1);
  assign w_src_bit  = |(r_src & (ADDR_W'(1) << w_cnt_m1));
  assign w_dst_bit  = |(r_dst & (ADDR_W'(1) << w_cnt_m1));
  assign w_data_bit = |(r_data & (DATA_W'(1) << w_cnt_m1));
  assign w_crc_bit  = |(w_crc & (CRC_W'(1) << w_cnt_m1));

  // Next field, counter and the bit to drive on the line for the next cycle
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_bit   = IDLE_LEVEL;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_next_state = S_START;
          w_next_bit   = START_BIT;
        end
      end
      S_START: begin
        w_next_state = S_SRC;
        w_next_cnt   = ADDR_LAST;
        w_next_bit   = r_src[ADDR_W-1];
      end
      S_SRC: begin
        if (r_cnt == '0) begin
          w_next_state = S_DST;
          w_next_cnt   = ADDR_LAST;
          w_next_bit   = r_dst[ADDR_W-1];
        end else begin
          w_next_cnt   = w_cnt_m1;
          w_next_bit   = w_src_bit;
        end
      end
      S_DST: begin
        if (r_cnt == '0) begin
          w_next_state = S_DATA;
          w_next_cnt   = DATA_LAST;
          w_next_bit   = r_data[DATA_W-1];
        end else begin
          w_next_cnt   = w_cnt_m1;
          w_next_bit   = w_dst_bit;
        end
      end
      S_DATA: begin
        if (r_cnt == '0) begin
          w_next_state = S_CRC;
          w_next_cnt   = CRC_LAST;
          w_next_bit   = w_crc[CRC_W-1];
        end else begin
          w_next_cnt   = w_cnt_m1;
          w_next_bit   = w_data_bit;
        end
      end
      S_CRC: begin
        if (r_cnt == '0) begin
          w_next_state = S_STOP;
          w_next_bit   = STOP_BIT;
        end else begin
          w_next_cnt   = w_cnt_m1;
          w_next_bit   = w_crc_bit;
        end
      end
      S_STOP: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // CRC absorbs each SRC/DST/DATA bit at the edge it is placed on the line,
  // so the register is final by the time the CRC field starts
  assign w_crc_en = (w_next_state == S_SRC) || (w_next_state == S_DST) ||
                    (w_next_state == S_DATA);

  crc_serial #(
    .CRC_W    (CRC_W),
    .CRC_POLY (CRC_POLY)
  ) u_crc (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (w_take),
    .en      (w_crc_en),
    .bit_in  (w_next_bit),
    .crc     (w_crc)
  );

  // Frame sequencing, payload latch on grant, and registered bus outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bus_out    <= IDLE_LEVEL;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_grant      <= '0;
      r_rr_ptr     <= '0;
      r_src        <= '0;
      r_dst        <= '0;
      r_data       <= '0;
    end else begin
      r_state      <= w_next_state;
      r_cnt        <= w_next_cnt;
      r_bus_out    <= w_next_bit;
      r_busy       <= (w_next_state != S_IDLE);
      r_frame_done <= (w_next_state == S_STOP);
      r_grant      <= w_take ? (N'(1) << w_winner) : '0;
      if (w_take) begin
        r_src    <= w_winner;
        r_dst    <= w_win_addr;
        r_data   <= w_win_data;
        r_rr_ptr <= (w_winner == ADDR_W'(N - 1)) ? '0 : w_winner + ADDR_W'(1);
      end
    end
  end

  assign bus.grant      = r_grant;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;
  assign bus.bus_out    = r_bus_out;

endmodule
`default_nettype wire

// File: tb/tb_serial_bus_arbiter_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_bus_arbiter_tx
// Description : Self-checking bench for serial_bus_arbiter_tx: a small
//               (N=4, ADDR_W=2, DATA_W=8) and a default-parameter instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_bus_arbiter_tx;
  import bus_pkg::*;

  localparam int SN = 4, SAW = 2, SDW = 8;
  localparam int DN = 16, DAW = 4, DDW = 64;
  localparam int CW = 4;
  localparam int S_FL = frame_len(SAW, SDW, CW);
  localparam int D_FL = frame_len(DAW, DDW, CW);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_ptr    = 0;
  bit   exp_bits[$];

  serial_bus_arbiter_tx_if #(.N(SN), .ADDR_W(SAW), .DATA_W(SDW)) sif ();
  serial_bus_arbiter_tx_if #(.N(DN), .ADDR_W(DAW), .DATA_W(DDW)) dif ();

  serial_bus_arbiter_tx #(.N(SN), .ADDR_W(SAW), .DATA_W(SDW)) dut_s (
    .clock (clk), .reset_n (rst_n), .bus (sif.slave));
  serial_bus_arbiter_tx dut_d (
    .clock (clk), .reset_n (rst_n), .bus (dif.slave));

  always #5 clk = ~clk;

  // Expected line sequence: message bits, CRC by polynomial long division
  function automatic void build_frame(input int aw, input int dw, input int src,
                                      input int dst, input logic [63:0] data);
    bit msg[$];
    bit work[$];
    logic [3:0] gp;
    gp = 4'b0011;
    exp_bits.delete();
    for (int i = aw - 1; i >= 0; i--) msg.push_back(bit'((src >> i) & 1));
    for (int i = aw - 1; i >= 0; i--) msg.push_back(bit'((dst >> i) & 1));
    for (int i = dw - 1; i >= 0; i--) msg.push_back(data[i]);
    work = msg;
    for (int i = 0; i < CW; i++) work.push_back(1'b0);
    for (int i = 0; i < msg.size(); i++) begin
      if (work[i]) begin
        work[i] = 1'b0;
        for (int j = 1; j <= CW; j++) work[i+j] = work[i+j] ^ gp[CW-j];
      end
    end
    exp_bits.push_back(1'b0);
    foreach (msg[i]) exp_bits.push_back(msg[i]);
    for (int k = 0; k < CW; k++) exp_bits.push_back(work[msg.size() + k]);
    exp_bits.push_back(1'b1);
  endfunction

  // Round-robin: first requester at or after the pointer, wrapping
  function automatic int rr_pick(input logic [SN-1:0] r, input int ptr);
    for (int k = 0; k < SN; k++) if (r[(ptr + k) % SN]) return (ptr + k) % SN;
    return -1;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
  endtask

  // Waits for a grant on the small instance and checks the whole frame.
  // At frame bit act_at (if >= 0) the channel's req is dropped and its data inverted.
  task automatic expect_frame_s(input int ch, input string name, input int act_at,
                                output int waited);
    int bit_err, busy_err, fd_err, gr_err, first_bad;
    logic got_b, exp_b;
    logic [7:0] d;
    logic [1:0] a;
    logic [SN-1:0] want_g;
    bit_err = 0; busy_err = 0; fd_err = 0; gr_err = 0; first_bad = -1;
    got_b = 1'b0; exp_b = 1'b0;
    waited = 0;
    @(negedge clk);
    while (sif.grant === '0 && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    want_g = SN'(1) << ch;
    n_checks++;
    if (sif.grant !== want_g) begin
      n_fail++;
      $display("FAIL %s grant: got %b expected %b", name, sif.grant, want_g);
      return;
    end
    d = sif.data[ch*SDW +: SDW];
    a = sif.rx_addr[ch*SAW +: SAW];
    build_frame(SAW, SDW, ch, int'(a), 64'(d));
    for (int i = 0; i < S_FL; i++) begin
      if (i > 0) @(negedge clk);
      if (i == act_at) begin
        sif.req[ch] = 1'b0;
        sif.data[ch*SDW +: SDW] = ~d;
      end
      if (sif.bus_out !== exp_bits[i]) begin
        if (first_bad < 0) begin
          first_bad = i; got_b = sif.bus_out; exp_b = exp_bits[i];
        end
        bit_err++;
      end
      if (sif.busy !== 1'b1) busy_err++;
      if (sif.frame_done !== (i == S_FL - 1)) fd_err++;
      if (i > 0 && sif.grant !== '0) gr_err++;
    end
    n_checks++;
    if (bit_err != 0) begin
      n_fail++;
      $display("FAIL %s bus_out: %0d wrong bits, first at bit %0d got %b expected %b",
               name, bit_err, first_bad, got_b, exp_b);
    end
    n_checks++;
    if (busy_err != 0) begin
      n_fail++;
      $display("FAIL %s busy: low in %0d frame cycles, expected 0", name, busy_err);
    end
    n_checks++;
    if (fd_err != 0) begin
      n_fail++;
      $display("FAIL %s frame_done: wrong in %0d cycles, expected 0", name, fd_err);
    end
    n_checks++;
    if (gr_err != 0) begin
      n_fail++;
      $display("FAIL %s grant pulse: high in %0d extra cycles, expected 0", name, gr_err);
    end
    @(negedge clk);
    n_checks++;
    if (sif.bus_out !== 1'b1 || sif.busy !== 1'b0 || sif.frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle after stop: bus_out=%b busy=%b frame_done=%b expected 1 0 0",
               name, sif.bus_out, sif.busy, sif.frame_done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sif.req = '0; sif.data = '0; sif.rx_addr = '0;
    dif.req = '0; dif.data = '0; dif.rx_addr = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (sif.bus_out !== 1'b1 || sif.grant !== '0 || sif.busy !== 1'b0 || sif.frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset small: bus_out=%b grant=%b busy=%b frame_done=%b expected 1 0000 0 0",
               sif.bus_out, sif.grant, sif.busy, sif.frame_done);
    end
    n_checks++;
    if (dif.bus_out !== 1'b1 || dif.grant !== '0 || dif.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset default: bus_out=%b grant=%h busy=%b expected 1 0 0",
               dif.bus_out, dif.grant, dif.busy);
    end
    rst_n = 1'b1;
    m_ptr = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (sif.bus_out !== 1'b1 || sif.busy !== 1'b0 || sif.grant !== '0) begin
      n_fail++;
      $display("FAIL idle no req: bus_out=%b busy=%b grant=%b expected 1 0 0000",
               sif.bus_out, sif.busy, sif.grant);
    end
  endtask

  task automatic test_single();
    int w;
    int ch;
    sif.data = 32'h0000_0001;
    sif.rx_addr = 8'b0000_0001;
    sif.req = 4'b0001;
    ch = rr_pick(sif.req, m_ptr);
    expect_frame_s(ch, "single", -1, w);
    sif.req = '0;
    m_ptr = (ch + 1) % SN;
    repeat (4) @(negedge clk);
    n_checks++;
    if (sif.grant !== '0 || sif.bus_out !== 1'b1) begin
      n_fail++;
      $display("FAIL single no regrant: grant=%b bus_out=%b expected 0000 1", sif.grant, sif.bus_out);
    end
  endtask

  task automatic test_default_cfg();
    int waited, bit_err, busy_err, fd_err;
    waited = 0; bit_err = 0; busy_err = 0; fd_err = 0;
    dif.data = '0;
    dif.rx_addr = '0;
    dif.data[DDW-1:0] = 64'h1;
    dif.rx_addr[DAW-1:0] = 4'h1;
    dif.req = 16'h0001;
    @(negedge clk);
    while (dif.grant === '0 && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    n_checks++;
    if (dif.grant !== 16'h0001) begin
      n_fail++;
      $display("FAIL default grant: got %h expected 0001", dif.grant);
    end
    dif.req = '0;
    build_frame(DAW, DDW, 0, 1, 64'h1);
    for (int i = 0; i < D_FL; i++) begin
      if (i > 0) @(negedge clk);
      if (dif.bus_out !== exp_bits[i]) bit_err++;
      if (dif.busy !== 1'b1) busy_err++;
      if (dif.frame_done !== (i == D_FL - 1)) fd_err++;
    end
    n_checks++;
    if (bit_err != 0 || busy_err != 0 || fd_err != 0) begin
      n_fail++;
      $display("FAIL default frame: bit_err=%0d busy_err=%0d done_err=%0d expected 0 0 0",
               bit_err, busy_err, fd_err);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (dif.bus_out !== 1'b1 || dif.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL default idle: bus_out=%b busy=%b expected 1 0", dif.bus_out, dif.busy);
    end
  endtask

  task automatic test_rr_all();
    int w, ch;
    apply_reset();
    sif.data = $urandom;
    sif.rx_addr = 8'($urandom);
    sif.req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      ch = rr_pick(sif.req, m_ptr);
      expect_frame_s(ch, "rr_all", -1, w);
      m_ptr = (ch + 1) % SN;
      if (f > 0) begin
        n_checks++;
        if (w != 0) begin
          n_fail++;
          $display("FAIL rr_all gap: %0d idle cycles expected 1", w + 1);
        end
      end
    end
    sif.req = '0;
  endtask

  task automatic test_wrap();
    int w, ch;
    apply_reset();
    sif.data = $urandom;
    sif.req = 4'b0100;
    ch = rr_pick(sif.req, m_ptr);
    expect_frame_s(ch, "wrap_pre", -1, w);
    m_ptr = (ch + 1) % SN;
    sif.req = 4'b1001;
    for (int f = 0; f < 2; f++) begin
      ch = rr_pick(sif.req, m_ptr);
      expect_frame_s(ch, "wrap", -1, w);
      m_ptr = (ch + 1) % SN;
    end
    sif.req = '0;
  endtask

  task automatic test_reset_mid();
    int w;
    apply_reset();
    sif.data = 32'h0;
    sif.req = 4'b0001;
    w = 0;
    @(negedge clk);
    while (sif.grant === '0 && w < 100) begin
      w++;
      @(negedge clk);
    end
    build_frame(SAW, SDW, 0, int'(sif.rx_addr[1:0]), 64'h0);
    repeat (10) @(negedge clk);
    n_checks++;
    if (sif.bus_out !== exp_bits[10] || sif.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid-frame bit 10: bus_out=%b busy=%b expected %b 1",
               sif.bus_out, sif.busy, exp_bits[10]);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (sif.bus_out !== 1'b1 || sif.busy !== 1'b0 || sif.grant !== '0 || sif.frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL async reset: bus_out=%b busy=%b grant=%b frame_done=%b expected 1 0 0000 0",
               sif.bus_out, sif.busy, sif.grant, sif.frame_done);
    end
    sif.req = 4'b0010;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    expect_frame_s(rr_pick(sif.req, m_ptr), "after_reset", -1, w);
    m_ptr = (rr_pick(sif.req, m_ptr) + 1) % SN;
    sif.req = '0;
  endtask

  task automatic test_drop_change();
    int w, ch, extra;
    sif.data = $urandom;
    sif.rx_addr = 8'($urandom);
    sif.req = 4'b0100;
    ch = rr_pick(sif.req, m_ptr);
    expect_frame_s(ch, "drop_change", 7, w);
    m_ptr = (ch + 1) % SN;
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sif.grant !== '0) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL drop_change regrant: %0d grants expected 0", extra);
    end
  endtask

  task automatic test_random();
    int w, ch;
    logic [SN-1:0] r;
    for (int it = 0; it < 12; it++) begin
      r = SN'($urandom_range(1, 15));
      sif.data = $urandom;
      sif.rx_addr = 8'($urandom);
      sif.req = r;
      ch = rr_pick(r, m_ptr);
      expect_frame_s(ch, "random", -1, w);
      m_ptr = (ch + 1) % SN;
    end
    sif.req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_default_cfg();
    test_rr_all();
    test_wrap();
    test_reset_mid();
    test_drop_change();
    test_random();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
